// File: rtl/seg_decoder_pkg.sv
// Shared display-link definitions: slot selects, segment codes, COMMAND bit
// positions and the slot-aware segment decoder used by both slot trackers.
package seg_decoder_pkg;

  localparam logic [3:0] SEL_LR    = 4'hE;
  localparam logic [3:0] SEL_FB    = 4'hD;
  localparam logic [3:0] SEL_BLANK = 4'hF;

  localparam logic [7:0] SEG_L   = 8'hC7;
  localparam logic [7:0] SEG_R   = 8'hAF;
  localparam logic [7:0] SEG_B   = 8'h83;
  localparam logic [7:0] SEG_F   = 8'h8E;
  localparam logic [7:0] SEG_NIL = 8'hFF;

  localparam int CMD_R = 0;
  localparam int CMD_L = 1;
  localparam int CMD_B = 2;
  localparam int CMD_F = 3;

  typedef enum logic {SLOT_LR, SLOT_FB} slot_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } seg_code_t;

  // Field code 2'b01 is R/B, 2'b10 is L/F, 2'b00 is a blank slot.
  function automatic seg_code_t decode_seg(slot_e slot, logic [7:0] digit);
    seg_code_t r;
    r.valid = 1'b1;
    r.code  = 2'b00;
    if (digit == SEG_NIL)
      r.code = 2'b00;
    else if (slot == SLOT_LR && digit == SEG_R)
      r.code = 2'b01;
    else if (slot == SLOT_LR && digit == SEG_L)
      r.code = 2'b10;
    else if (slot == SLOT_FB && digit == SEG_B)
      r.code = 2'b01;
    else if (slot == SLOT_FB && digit == SEG_F)
      r.code = 2'b10;
    else
      r.valid = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] pack_command(logic [1:0] lr, logic [1:0] fb);
    logic [3:0] c;
    c        = 4'h0;
    c[CMD_R] = lr[0];
    c[CMD_L] = lr[1];
    c[CMD_B] = fb[0];
    c[CMD_F] = fb[1];
    return c;
  endfunction

endpackage

// File: rtl/seg_field_track.sv
// One command field: debounces repeated slot codes into a confirmed field value
// and clears it after the slot has been silent for TIMEOUT cycles.
module seg_field_track
  import seg_decoder_pkg::*;
#(
  parameter int    CONFIRM = 2,
  parameter int    TIMEOUT = 8,
  parameter slot_e SLOT    = SLOT_LR
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       slot_active_i,
  input  logic [7:0] digit_i,
  output logic       sighting_o,
  output logic       illegal_o,
  output logic [1:0] field_o,
  output logic [1:0] field_next_o,
  output logic       silent_next_o
);

  localparam logic [2:0] CONFIRM_C = 3'(CONFIRM);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0] cand_q, cand_d;
  logic [2:0] count_q, count_d;
  logic [1:0] field_q, field_d;
  logic [7:0] silence_q, silence_d;
  seg_code_t  dec;
  logic       sighting;
  logic       illegal;

  always_comb begin
    dec       = decode_seg(SLOT, digit_i);
    sighting  = slot_active_i & dec.valid;
    illegal   = slot_active_i & ~dec.valid;
    cand_d    = cand_q;
    count_d   = count_q;
    field_d   = field_q;
    silence_d = sighting ? 8'd0
              : (silence_q == TIMEOUT_C) ? silence_q : silence_q + 8'd1;

    if (sighting) begin
      if (dec.code == cand_q) begin
        count_d = (count_q >= CONFIRM_C) ? CONFIRM_C : count_q + 3'd1;
      end else begin
        cand_d  = dec.code;
        count_d = 3'd1;
      end
      if (count_d == CONFIRM_C)
        field_d = cand_d;
    end else if (illegal) begin
      // A corrupted sample breaks the run but keeps the candidate.
      count_d = 3'd0;
    end

    if (silence_d == TIMEOUT_C) begin
      field_d = 2'b00;
      cand_d  = 2'b00;
      count_d = 3'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cand_q    <= 2'b00;
      count_q   <= 3'd0;
      field_q   <= 2'b00;
      silence_q <= 8'd0;
    end else begin
      cand_q    <= cand_d;
      count_q   <= count_d;
      field_q   <= field_d;
      silence_q <= silence_d;
    end
  end

  assign sighting_o    = sighting;
  assign illegal_o     = illegal;
  assign field_o       = field_q;
  assign field_next_o  = field_d;
  assign silent_next_o = (silence_d == TIMEOUT_C);

endmodule

// File: rtl/seg_decoder.sv
// Reconstructs the 4-bit motion command from the multiplexed 7-segment
// display drive, with per-slot debounce, timeout and link-lock tracking.
module seg_decoder
  import seg_decoder_pkg::*;
#(
  parameter int CONFIRM = 2,
  parameter int TIMEOUT = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] SEL,
  input  logic [7:0] DIGIT,
  output logic [3:0] COMMAND,
  output logic       UPDATE,
  output logic       ERR,
  output logic       LOCKED
);

  localparam logic SEARCH = 1'b0;
  localparam logic TRACK  = 1'b1;

  logic       state_q, state_d;
  logic       update_q, update_d;
  logic       err_q, err_d;
  logic       lr_sighting, fb_sighting;
  logic       lr_illegal, fb_illegal;
  logic       lr_silent, fb_silent;
  logic [1:0] lr_field, fb_field;
  logic [1:0] lr_field_next, fb_field_next;
  logic       sel_illegal, blank_illegal;

  seg_field_track #(.CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT), .SLOT(SLOT_LR)) u_lr (
    .CLK           (CLK),
    .RESET         (RESET),
    .slot_active_i (SEL == SEL_LR),
    .digit_i       (DIGIT),
    .sighting_o    (lr_sighting),
    .illegal_o     (lr_illegal),
    .field_o       (lr_field),
    .field_next_o  (lr_field_next),
    .silent_next_o (lr_silent)
  );

  seg_field_track #(.CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT), .SLOT(SLOT_FB)) u_fb (
    .CLK           (CLK),
    .RESET         (RESET),
    .slot_active_i (SEL == SEL_FB),
    .digit_i       (DIGIT),
    .sighting_o    (fb_sighting),
    .illegal_o     (fb_illegal),
    .field_o       (fb_field),
    .field_next_o  (fb_field_next),
    .silent_next_o (fb_silent)
  );

  always_comb begin
    sel_illegal   = (SEL != SEL_LR) && (SEL != SEL_FB) && (SEL != SEL_BLANK);
    blank_illegal = (SEL == SEL_BLANK) && (DIGIT != SEG_NIL);
    err_d         = lr_illegal | fb_illegal | sel_illegal | blank_illegal;
    // Both fields may move on the same edge; compare whole words for one pulse.
    update_d      = pack_command(lr_field_next, fb_field_next)
                    != pack_command(lr_field, fb_field);
    state_d       = state_q;
    case (state_q)
      SEARCH:  if (lr_sighting || fb_sighting) state_d = TRACK;
      TRACK:   if (lr_silent && fb_silent) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= SEARCH;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign COMMAND = pack_command(lr_field, fb_field);
  assign UPDATE  = update_q;
  assign ERR     = err_q;
  assign LOCKED  = (state_q == TRACK);

endmodule

// File: tb/tb_seg_decoder.sv
// Directed bench for seg_decoder: each step drives one SEL/DIGIT sample and
// checks {COMMAND, UPDATE, ERR, LOCKED} just after the sampling edge.
module tb_seg_decoder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] SEL;
  logic [7:0] DIGIT;
  logic [3:0] COMMAND;
  logic       UPDATE;
  logic       ERR;
  logic       LOCKED;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  seg_decoder #(.CONFIRM(2), .TIMEOUT(8)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SEL     (SEL),
    .DIGIT   (DIGIT),
    .COMMAND (COMMAND),
    .UPDATE  (UPDATE),
    .ERR     (ERR),
    .LOCKED  (LOCKED)
  );

  task automatic step(input logic [3:0] s, input logic [7:0] d);
    SEL   = s;
    DIGIT = d;
    @(posedge CLK);
    #1;
    $display("t=%0t rst=%b sel=%h digit=%h -> command=%b update=%b err=%b locked=%b",
             $time, RESET, s, d, COMMAND, UPDATE, ERR, LOCKED);
  endtask

  // exp = {COMMAND, UPDATE, ERR, LOCKED}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {COMMAND, UPDATE, ERR, LOCKED};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed cmd/upd/err/lck=%b_%b_%b_%b expected %b_%b_%b_%b",
             tag, obs[6:3], obs[2], obs[1], obs[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    RESET = 1'b1;
    SEL   = 4'hF;
    DIGIT = 8'hFF;
    step(4'hF, 8'hFF);
    step(4'hF, 8'hFF);
    chk("reset", 7'b0000_0_0_0);
    RESET = 1'b0;

    // R source: E/AF alternating with blank
    step(4'hE, 8'hAF); chk("r_first",   7'b0000_0_0_1);
    step(4'hF, 8'hFF); chk("r_blank",   7'b0000_0_0_1);
    step(4'hE, 8'hAF); chk("r_confirm", 7'b0001_1_0_1);
    step(4'hF, 8'hFF); chk("r_hold",    7'b0001_0_0_1);

    // Illegal LR code inside R stream
    step(4'hE, 8'h83); chk("lr_bad_err",  7'b0001_0_1_1);
    step(4'hF, 8'hFF); chk("lr_bad_clr",  7'b0001_0_0_1);
    step(4'hE, 8'hAF); chk("lr_bad_keep", 7'b0001_0_0_1);

    // Add B to reach 0101
    step(4'hD, 8'h83); chk("b_first",   7'b0001_0_0_1);
    step(4'hD, 8'h83); chk("b_confirm", 7'b0101_1_0_1);

    // Stream stops: LR times out first, then FB
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 8'hFF); chk("stop_hold", 7'b0101_0_0_1);
    end
    step(4'hF, 8'hFF); chk("lr_timeout", 7'b0100_1_0_1);
    step(4'hF, 8'hFF); chk("fb_wait",    7'b0100_0_0_1);
    step(4'hF, 8'hFF); chk("fb_timeout", 7'b0000_1_0_0);
    step(4'hF, 8'hFF); chk("unlocked",   7'b0000_0_0_0);

    // 0001 then source change to 1010
    step(4'hE, 8'hAF); chk("relock",     7'b0000_0_0_1);
    step(4'hD, 8'hFF); chk("fb_nil",     7'b0000_0_0_1);
    step(4'hE, 8'hAF); chk("r_again",    7'b0001_1_0_1);
    step(4'hE, 8'hC7); chk("l_first",    7'b0001_0_0_1);
    step(4'hD, 8'h8E); chk("f_first",    7'b0001_0_0_1);
    step(4'hE, 8'hC7); chk("l_confirm",  7'b0010_1_0_1);
    step(4'hD, 8'h8E); chk("f_confirm",  7'b1010_1_0_1);
    step(4'hF, 8'hFF); chk("lf_hold",    7'b1010_0_0_1);

    // FB-only stream: B confirms on the same edge LR times out
    for (int i = 0; i < 4; i++) begin
      step(4'hD, 8'h8E); chk("f_only", 7'b1010_0_0_1);
    end
    step(4'hD, 8'h83); chk("b_cand",     7'b1010_0_0_1);
    step(4'hD, 8'h83); chk("both_edge",  7'b0100_1_0_1);
    step(4'hD, 8'h83); chk("b_only",     7'b0100_0_0_1);

    // Illegal SEL/DIGIT pairs
    step(4'hD, 8'hAF); chk("fb_bad",     7'b0100_0_1_1);
    step(4'hB, 8'hFF); chk("sel_bad",    7'b0100_0_1_1);
    step(4'hF, 8'h00); chk("blank_bad",  7'b0100_0_1_1);
    step(4'hF, 8'hFF); chk("err_clear",  7'b0100_0_0_1);

    // Reset discards a partial match
    RESET = 1'b1;
    step(4'hF, 8'hFF); chk("reset2",     7'b0000_0_0_0);
    RESET = 1'b0;
    step(4'hE, 8'hAF); chk("pre_rst_r",  7'b0000_0_0_1);
    RESET = 1'b1;
    step(4'hF, 8'hFF); chk("mid_reset",  7'b0000_0_0_0);
    RESET = 1'b0;
    step(4'hE, 8'hAF); chk("post_rst_1", 7'b0000_0_0_1);
    step(4'hE, 8'hAF); chk("post_rst_2", 7'b0001_1_0_1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 The block SHALL have parameter CONFIRM, default 2, meaning the number of consecutive identical sightings of a slot code required before that field is updated (legal range 1..7).
REQ-002 The block SHALL have parameter TIMEOUT, default 8, meaning the number of cycles without a sighting of a slot after which that field is cleared (legal range 2..255).
REQ-003 The block SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 The block SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port SEL  input  4  active-low digit select from the display driver (4'hE = LR slot, 4'hD = FB slot, 4'hF = blank).
REQ-006 The block SHALL have port DIGIT  input  8  active-low segment pattern from the display driver.
REQ-007 The block SHALL have port COMMAND  output  4  registered reconstructed command: bit0 R, bit1 L, bit2 B, bit3 F.
REQ-008 The block SHALL have port UPDATE  output  1  one-cycle pulse in the cycle after COMMAND changes value.
REQ-009 The block SHALL have port ERR  output  1  one-cycle pulse in the cycle after an illegal SEL/DIGIT pair is sampled.
REQ-010 The block SHALL have port LOCKED  output  1  high while at least one slot has been sighted within the last TIMEOUT cycles.

Function
REQ-011 SEL and DIGIT SHALL be sampled every rising edge; same clock domain as the driver, so there is no synchronizer.
REQ-012 Legal LR-slot codes: DIGIT 8'hAF -> LR field 2'b01 (R); 8'hC7 -> 2'b10 (L); 8'hFF -> 2'b00.
REQ-013 Legal FB-slot codes: DIGIT 8'h83 -> FB field 2'b01 (B); 8'h8E -> 2'b10 (F); 8'hFF -> 2'b00.
REQ-014 Illegal samples: a SEL value other than E/D/F; a slot SEL with an unlisted DIGIT; or SEL=F with DIGIT != 8'hFF. An illegal sample SHALL pulse ERR, reset that slot's match count, and leave the fields unchanged.
REQ-015 Each field SHALL hold a candidate code and a 3-bit match count.
REQ-016 On a legal slot sighting equal to the candidate, the count SHALL increment, saturating at CONFIRM.
REQ-017 On a legal slot sighting that differs from the candidate, the candidate SHALL be replaced and the count set to 1.
REQ-018 A field SHALL take the candidate value at the edge on which the count reaches CONFIRM; COMMAND is visible in the following cycle, giving a latency of 1 cycle after the confirming sample.
REQ-019 Each field SHALL have an 8-bit silence counter that is cleared on a legal sighting of its slot and otherwise increments, saturating at TIMEOUT.
REQ-020 On reaching TIMEOUT, the field, candidate and count SHALL be cleared to 0; this is how "no LR/FB command" shown as a blank slot is recovered.
REQ-021 Simultaneous timeout of one field and confirmation of the other SHALL both take effect at the same edge, with a single UPDATE pulse.
REQ-022 The FSM SHALL have the states SEARCH and TRACK.
REQ-023 SEARCH -> TRACK on the first legal slot sighting; TRACK -> SEARCH when both silence counters are at TIMEOUT. LOCKED = (state == TRACK).
REQ-024 Blank samples (SEL=F, DIGIT=FF) SHALL be legal and SHALL NOT modify candidates or counts.

Reset
REQ-025 While RESET is high, at the clock edge: COMMAND=4'h0, UPDATE=0, ERR=0, LOCKED=0, state=SEARCH, all candidates/counts=0, silence counters=0.
REQ-026 RESET asserted mid-confirmation SHALL discard partial matches; after deassertion, a full CONFIRM sightings are required again.

Structure
REQ-027 SEL slot encodings, the five segment codes (L C7, R AF, B 83, F 8E, NIL FF) and the COMMAND bit indices SHALL live in a shared package used by both the display driver and this block.
REQ-028 Per-field logic (candidate, count, silence counter, field register) SHALL be one sub-module, seg_field_track, instantiated twice with the legal code table selected by a parameter.

Verification
REQ-029 Driver pattern with COMMAND source 4'b0001 (E/AF, F/FF alternating from cycle 1) -> COMMAND=4'b0001 after the second LR sighting (edge 3), UPDATE pulse at cycle 4, LOCKED=1 from cycle 2.
REQ-030 Source changes 0001 -> 1010 mid-stream -> COMMAND passes through a single intermediate value at most, settles at 1010 within 4 cycles; one UPDATE per change.
REQ-031 SEL=E with DIGIT=8'h83 for one cycle inside a valid R stream -> ERR pulse, COMMAND stays 0001, reconfirmation needs 2 more sightings only if the code changes.
REQ-032 Stream stops (SEL=F, DIGIT=FF constant) with COMMAND=0101 -> both fields cleared to 0000 after TIMEOUT=8 cycles, UPDATE pulse, LOCKED falls.
REQ-033 RESET asserted for 1 cycle after one R sighting -> COMMAND remains 0000 until 2 further R sightings.
REQ-034 Only the FB slot active (LR blank) with B -> COMMAND=0100 and the LR field stays 00 with no ERR.
